// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO using all 2^DEPTH_WIDTH slots, with occupancy count, threshold flags,
// flush and sticky error flags. Define FIFO_FWFT_EN for first-word fall-through pop_data.
module fifo_sync_flex #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH_WIDTH   = 3,
    parameter int AFULL_THRESH  = (1 << DEPTH_WIDTH) - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push_en,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_avail,
    input  logic                  pop_en,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_avail,
    output logic [DEPTH_WIDTH:0]  count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] FULL_COUNT = {1'b1, {DEPTH_WIDTH{1'b0}}};
    localparam logic [DEPTH_WIDTH:0] AF_LEVEL   = AFULL_THRESH[DEPTH_WIDTH:0];
    localparam logic [DEPTH_WIDTH:0] AE_LEVEL   = AEMPTY_THRESH[DEPTH_WIDTH:0];

    logic [DATA_WIDTH-1:0]  storage [DEPTH];
    logic [DEPTH_WIDTH-1:0] head;
    logic [DEPTH_WIDTH-1:0] tail;
    logic [DEPTH_WIDTH:0]   count_q;
    logic                   push_fire;
    logic                   pop_fire;
    logic                   overflow_q;
    logic                   underflow_q;

    assign push_avail   = (count_q != FULL_COUNT);
    assign pop_avail    = (count_q != '0);
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_LEVEL);
    assign almost_empty = (count_q <= AE_LEVEL);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Flush drops both requests, so neither fires nor counts as an error.
    assign push_fire = push_en && push_avail && !flush;
    assign pop_fire  = pop_en && pop_avail && !flush;

    always_ff @(posedge clk) begin
        if (push_fire && !rst) begin
            storage[tail] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push_fire) begin
                tail <= tail + 1'b1;
            end
            if (pop_fire) begin
                head <= head + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (!flush) begin
            overflow_q  <= overflow_q  | (push_en && !push_avail);
            underflow_q <= underflow_q | (pop_en && !pop_avail);
        end
    end

`ifdef FIFO_FWFT_EN
    assign pop_data = pop_avail ? storage[head] : '0;
`else
    // Read port registered: the popped word appears the cycle after pop_fire and holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_data <= '0;
        end else if (pop_fire) begin
            pop_data <= storage[head];
        end
    end
`endif

endmodule
